n64_poll_host: RTL

//  Host-side master for the N64 single-wire, open-drain controller bus; the initiator counterpart of the bench device model.
//  On start: serialises an 8-bit command plus stop bit, releases the line, then times and decodes the 32-bit reply.

---
 rtl/n64_poll_host.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/n64_poll_host.sv
// N64 controller-bus host: sends an 8-bit command plus stop bit, then decodes the 32-bit reply.
// No handshake on the game side; start is taken only in IDLE. The reply bits are time-sampled; a missing edge raises timeout.
module n64_poll_host #(
  parameter int BIT_TICKS     = 40,
  parameter int SHORT_TICKS   = 10,
  parameter int LONG_TICKS    = 30,
  parameter int SAMPLE_TICKS  = 20,
  parameter int TIMEOUT_TICKS = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  inout  wire         data,
  output logic        busy,
  output logic        valid,
  output logic [31:0] resp,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TW-1:0] TK_BIT_END  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TK_SHORT    = TW'(SHORT_TICKS);
  localparam logic [TW-1:0] TK_LONG     = TW'(LONG_TICKS);
  localparam logic [TW-1:0] TK_STOP_END = TW'(SHORT_TICKS - 1);
  localparam logic [TW-1:0] TK_SAMPLE   = TW'(SAMPLE_TICKS);
  localparam logic [TW-1:0] TK_TIMEOUT  = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TK_MAX      = {TW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_BIT,
    HOLDOFF
  } state_t;

  state_t         state;
  logic [TW-1:0]  tick;
  logic [5:0]     bitcnt;
  logic [7:0]     txsr;
  logic [31:0]    rxsr;
  logic           drive_low;
  logic           sync0;
  logic           sync1;
  logic           sync_prev;

  logic           fall;
  logic [TW-1:0]  tick_inc;
  logic [TW-1:0]  low_len;

  // Open-drain: only ever pull low, the pull-up supplies the high level.
  assign data = drive_low ? 1'b0 : 1'bz;

  assign fall     = sync_prev & ~sync1;
  assign tick_inc = (tick == TK_MAX) ? tick : tick + 1'b1;
  assign low_len  = txsr[7] ? TK_SHORT : TK_LONG;

  // Synchroniser resets to the idle-high level so reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0     <= 1'b1;
      sync1     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync0     <= data;
      sync1     <= sync0;
      sync_prev <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick      <= '0;
      bitcnt    <= '0;
      txsr      <= '0;
      rxsr      <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      resp      <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          drive_low <= 1'b0;
          if (start) begin
            txsr      <= cmd;
            tick      <= '0;
            bitcnt    <= '0;
            busy      <= 1'b1;
            drive_low <= 1'b1;
            state     <= TX_BIT;
          end
        end

        TX_BIT: begin
          if (tick == TK_BIT_END) begin
            tick      <= '0;
            drive_low <= 1'b1;
            txsr      <= {txsr[6:0], 1'b0};
            if (bitcnt == 6'd7) begin
              bitcnt <= '0;
              state  <= TX_STOP;
            end else begin
              bitcnt <= bitcnt + 6'd1;
            end
          end else begin
            tick      <= tick_inc;
            drive_low <= (tick_inc < low_len);
          end
        end

        TX_STOP: begin
          if (tick == TK_STOP_END) begin
            tick      <= '0;
            drive_low <= 1'b0;
            bitcnt    <= '0;
            state     <= RX_WAIT;
          end else begin
            tick <= tick_inc;
          end
        end

        RX_WAIT: begin
          if (fall) begin
            tick  <= '0;
            state <= RX_BIT;
          end else if (tick >= TK_TIMEOUT) begin
            timeout <= 1'b1;
            tick    <= '0;
            state   <= HOLDOFF;
          end else begin
            tick <= tick_inc;
          end
        end

        RX_BIT: begin
          if (tick == TK_SAMPLE) begin
            rxsr   <= {rxsr[30:0], sync1};
            bitcnt <= bitcnt + 6'd1;
            tick   <= '0;
            if (bitcnt == 6'd31) begin
              resp  <= {rxsr[30:0], sync1};
              valid <= 1'b1;
              state <= HOLDOFF;
            end else begin
              state <= RX_WAIT;
            end
          end else begin
            tick <= tick_inc;
          end
        end

        HOLDOFF: begin
          // Count consecutive high cycles; any low (device stop bit) restarts the count.
          if (!sync1) begin
            tick <= '0;
          end else if (tick == TK_BIT_END) begin
            tick  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tick <= tick_inc;
          end
        end

        default: begin
          drive_low <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
